// File: rtl/mux_pkg.sv
// Shared widths and word type for the 32:1 word multiplexer.
// Optional parity output is enabled with MUX32X32_PARITY_EN.
package mux_pkg;

   localparam int unsigned MUX_DATA_W    = 32;
   localparam int unsigned MUX_NUM_IN    = 32;
   localparam int unsigned MUX_SEL_W     = $clog2(MUX_NUM_IN);
   localparam int unsigned MUX_GRP_SIZE  = 8;
   localparam int unsigned MUX_GRP_SEL_W = $clog2(MUX_GRP_SIZE);
   localparam int unsigned MUX_NUM_GRP   = MUX_NUM_IN / MUX_GRP_SIZE;

   typedef logic [MUX_DATA_W-1:0] mux_word_t;

   // Even parity bit: set when the word holds an odd number of ones.
   function automatic logic even_parity(input mux_word_t w);
      return ^w;
   endfunction

endpackage

// File: rtl/mux8x32.sv
// 8:1 multiplexer of 32-bit words; one first-level slice of mux32x32.
module mux8x32
   import mux_pkg::*;
(
   input  logic [MUX_GRP_SIZE-1:0][MUX_DATA_W-1:0] i_word,
   input  logic [MUX_GRP_SEL_W-1:0]                i_sel,
   output logic [MUX_DATA_W-1:0]                   o_word_c
);

   // An X/Z select propagates X in simulation through the indexed read.
   assign o_word_c = i_word[i_sel];

endmodule

// File: rtl/mux32x32.sv
// 32:1 word multiplexer with combinational and registered outputs.
// Define MUX32X32_PARITY_EN to add the registered even-parity output par_q.
module mux32x32
   import mux_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [MUX_DATA_W-1:0] in0,
   input  logic [MUX_DATA_W-1:0] in1,
   input  logic [MUX_DATA_W-1:0] in2,
   input  logic [MUX_DATA_W-1:0] in3,
   input  logic [MUX_DATA_W-1:0] in4,
   input  logic [MUX_DATA_W-1:0] in5,
   input  logic [MUX_DATA_W-1:0] in6,
   input  logic [MUX_DATA_W-1:0] in7,
   input  logic [MUX_DATA_W-1:0] in8,
   input  logic [MUX_DATA_W-1:0] in9,
   input  logic [MUX_DATA_W-1:0] in10,
   input  logic [MUX_DATA_W-1:0] in11,
   input  logic [MUX_DATA_W-1:0] in12,
   input  logic [MUX_DATA_W-1:0] in13,
   input  logic [MUX_DATA_W-1:0] in14,
   input  logic [MUX_DATA_W-1:0] in15,
   input  logic [MUX_DATA_W-1:0] in16,
   input  logic [MUX_DATA_W-1:0] in17,
   input  logic [MUX_DATA_W-1:0] in18,
   input  logic [MUX_DATA_W-1:0] in19,
   input  logic [MUX_DATA_W-1:0] in20,
   input  logic [MUX_DATA_W-1:0] in21,
   input  logic [MUX_DATA_W-1:0] in22,
   input  logic [MUX_DATA_W-1:0] in23,
   input  logic [MUX_DATA_W-1:0] in24,
   input  logic [MUX_DATA_W-1:0] in25,
   input  logic [MUX_DATA_W-1:0] in26,
   input  logic [MUX_DATA_W-1:0] in27,
   input  logic [MUX_DATA_W-1:0] in28,
   input  logic [MUX_DATA_W-1:0] in29,
   input  logic [MUX_DATA_W-1:0] in30,
   input  logic [MUX_DATA_W-1:0] in31,
   input  logic [MUX_SEL_W-1:0]  sel,
   output logic [MUX_DATA_W-1:0] out,
`ifdef MUX32X32_PARITY_EN
   output logic                  par_q,
`endif
   output logic [MUX_DATA_W-1:0] out_q
);

   logic [MUX_NUM_IN-1:0][MUX_DATA_W-1:0]  w_in;
   logic [MUX_NUM_GRP-1:0][MUX_DATA_W-1:0] w_grp;

   assign w_in[0]  = in0;
   assign w_in[1]  = in1;
   assign w_in[2]  = in2;
   assign w_in[3]  = in3;
   assign w_in[4]  = in4;
   assign w_in[5]  = in5;
   assign w_in[6]  = in6;
   assign w_in[7]  = in7;
   assign w_in[8]  = in8;
   assign w_in[9]  = in9;
   assign w_in[10] = in10;
   assign w_in[11] = in11;
   assign w_in[12] = in12;
   assign w_in[13] = in13;
   assign w_in[14] = in14;
   assign w_in[15] = in15;
   assign w_in[16] = in16;
   assign w_in[17] = in17;
   assign w_in[18] = in18;
   assign w_in[19] = in19;
   assign w_in[20] = in20;
   assign w_in[21] = in21;
   assign w_in[22] = in22;
   assign w_in[23] = in23;
   assign w_in[24] = in24;
   assign w_in[25] = in25;
   assign w_in[26] = in26;
   assign w_in[27] = in27;
   assign w_in[28] = in28;
   assign w_in[29] = in29;
   assign w_in[30] = in30;
   assign w_in[31] = in31;

   // First level: four 8:1 slices on the low select bits.
   for (genvar g = 0; g < MUX_NUM_GRP; g++) begin : g_slice
      mux8x32 u_mux8x32 (
         .i_word   (w_in[g*MUX_GRP_SIZE +: MUX_GRP_SIZE]),
         .i_sel    (sel[MUX_GRP_SEL_W-1:0]),
         .o_word_c (w_grp[g])
      );
   end

   // Second level: 4:1 on the high select bits.
   assign out = w_grp[sel[MUX_SEL_W-1:MUX_GRP_SEL_W]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
`ifdef MUX32X32_PARITY_EN
         par_q <= 1'b0;
`endif
      end else begin
         out_q <= out;
`ifdef MUX32X32_PARITY_EN
         par_q <= even_parity(out);
`endif
      end
   end

endmodule

// File: tb/tb_mux32x32.sv
// Self-checking bench for mux32x32: directed scenarios plus randomized traffic
// against an array-indexed reference; parity checks when MUX32X32_PARITY_EN is set.
`timescale 1ns/1ps
module tb_mux32x32;

   logic        clk;
   logic        tb_rst;
   logic [31:0] tb_in [32];
   logic [4:0]  tb_sel;
   logic [31:0] tb_out;
   logic [31:0] tb_out_q;
`ifdef MUX32X32_PARITY_EN
   logic        tb_par_q;
`endif

   int total;
   int bad;

   mux32x32 dut (
      .clk   (clk),
      .rst   (tb_rst),
      .in0   (tb_in[0]),  .in1  (tb_in[1]),  .in2  (tb_in[2]),  .in3  (tb_in[3]),
      .in4   (tb_in[4]),  .in5  (tb_in[5]),  .in6  (tb_in[6]),  .in7  (tb_in[7]),
      .in8   (tb_in[8]),  .in9  (tb_in[9]),  .in10 (tb_in[10]), .in11 (tb_in[11]),
      .in12  (tb_in[12]), .in13 (tb_in[13]), .in14 (tb_in[14]), .in15 (tb_in[15]),
      .in16  (tb_in[16]), .in17 (tb_in[17]), .in18 (tb_in[18]), .in19 (tb_in[19]),
      .in20  (tb_in[20]), .in21 (tb_in[21]), .in22 (tb_in[22]), .in23 (tb_in[23]),
      .in24  (tb_in[24]), .in25 (tb_in[25]), .in26 (tb_in[26]), .in27 (tb_in[27]),
      .in28  (tb_in[28]), .in29 (tb_in[29]), .in30 (tb_in[30]), .in31 (tb_in[31]),
      .sel   (tb_sel),
      .out   (tb_out),
`ifdef MUX32X32_PARITY_EN
      .par_q (tb_par_q),
`endif
      .out_q (tb_out_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Even parity as a population count, independent of the XOR tree.
   function automatic logic ref_parity(input logic [31:0] w);
      return 1'(($countones(w) % 2) == 1);
   endfunction

   task automatic load_pattern();
      for (int i = 0; i < 32; i++) tb_in[i] = 32'hDEAD0000 + 32'(i);
   endtask

   task automatic test_reset();
      tb_rst = 1'b1;
      load_pattern();
      tb_sel = 5'd9;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (tb_out_q !== 32'h0) begin
         bad++;
         $display("FAIL reset_out_q sel=%0d got=%h want=%h", tb_sel, tb_out_q, 32'h0);
      end
      total++;
      if (tb_out !== 32'hDEAD0009) begin
         bad++;
         $display("FAIL reset_out_tracks sel=%0d got=%h want=%h", tb_sel, tb_out, 32'hDEAD0009);
      end
`ifdef MUX32X32_PARITY_EN
      total++;
      if (tb_par_q !== 1'b0) begin
         bad++;
         $display("FAIL reset_par_q sel=%0d got=%b want=0", tb_sel, tb_par_q);
      end
`endif
   endtask

   task automatic test_sweep();
      load_pattern();
      for (int s = 0; s < 32; s++) begin
         tb_sel = 5'(s);
         #5;
         total++;
         if (tb_out !== 32'hDEAD0000 + 32'(s)) begin
            bad++;
            $display("FAIL sweep sel=%0d got=%h want=%h", s, tb_out, 32'hDEAD0000 + 32'(s));
         end
      end
   endtask

   task automatic test_unselected();
      load_pattern();
      tb_sel = 5'd7;
      #1;
      tb_in[6] = $urandom;
      tb_in[8] = $urandom;
      #1;
      total++;
      if (tb_out !== 32'hDEAD0007) begin
         bad++;
         $display("FAIL unselected sel=%0d got=%h want=%h", tb_sel, tb_out, 32'hDEAD0007);
      end
      tb_in[7] = 32'h12345678;
      #1;
      total++;
      if (tb_out !== 32'h12345678) begin
         bad++;
         $display("FAIL selected_change sel=%0d got=%h want=%h", tb_sel, tb_out, 32'h12345678);
      end
   endtask

   task automatic test_register();
      load_pattern();
      @(negedge clk);
      tb_rst = 1'b1;
      tb_sel = 5'd31;
      #1;
      tb_rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (tb_out_q !== 32'hDEAD001F) begin
         bad++;
         $display("FAIL first_capture sel=%0d got=%h want=%h", tb_sel, tb_out_q, 32'hDEAD001F);
      end
      tb_sel = 5'd0;
      #2;
      total++;
      if (tb_out_q !== 32'hDEAD001F) begin
         bad++;
         $display("FAIL hold sel=%0d got=%h want=%h", tb_sel, tb_out_q, 32'hDEAD001F);
      end
      @(posedge clk);
      #1;
      total++;
      if (tb_out_q !== 32'hDEAD0000) begin
         bad++;
         $display("FAIL next_capture sel=%0d got=%h want=%h", tb_sel, tb_out_q, 32'hDEAD0000);
      end
   endtask

   task automatic test_async_reset();
      load_pattern();
      tb_sel = 5'd5;
      @(posedge clk);
      #1;
      total++;
      if (tb_out_q !== 32'hDEAD0005) begin
         bad++;
         $display("FAIL pre_reset sel=%0d got=%h want=%h", tb_sel, tb_out_q, 32'hDEAD0005);
      end
      #2;
      tb_rst = 1'b1;
      #1;
      total++;
      if (tb_out_q !== 32'h0) begin
         bad++;
         $display("FAIL async_clear sel=%0d got=%h want=%h", tb_sel, tb_out_q, 32'h0);
      end
      total++;
      if (tb_out !== 32'hDEAD0005) begin
         bad++;
         $display("FAIL out_in_reset sel=%0d got=%h want=%h", tb_sel, tb_out, 32'hDEAD0005);
      end
      @(negedge clk);
      tb_rst = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] exp_q;
      logic [4:0]  s;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         for (int i = 0; i < 32; i++) tb_in[i] = $urandom;
         s = 5'($urandom_range(0, 31));
         tb_sel = s;
         #1;
         total++;
         if (tb_out !== tb_in[s]) begin
            bad++;
            $display("FAIL rand_out sel=%0d got=%h want=%h", s, tb_out, tb_in[s]);
         end
         exp_q = tb_in[s];
         @(posedge clk);
         #1;
         total++;
         if (tb_out_q !== exp_q) begin
            bad++;
            $display("FAIL rand_out_q sel=%0d got=%h want=%h", s, tb_out_q, exp_q);
         end
`ifdef MUX32X32_PARITY_EN
         total++;
         if (tb_par_q !== ref_parity(exp_q)) begin
            bad++;
            $display("FAIL rand_par_q sel=%0d got=%b want=%b", s, tb_par_q, ref_parity(exp_q));
         end
`endif
         tb_sel = 5'($urandom_range(0, 31));
         tb_in[s] = ~exp_q;
         #1;
         total++;
         if (tb_out_q !== exp_q) begin
            bad++;
            $display("FAIL rand_hold sel=%0d got=%h want=%h", tb_sel, tb_out_q, exp_q);
         end
      end
   endtask

`ifdef MUX32X32_PARITY_EN
   task automatic test_parity();
      @(negedge clk);
      tb_in[3] = 32'h00000007;
      tb_sel = 5'd3;
      @(posedge clk);
      #1;
      total++;
      if (tb_par_q !== 1'b1) begin
         bad++;
         $display("FAIL parity_odd sel=%0d got=%b want=1", tb_sel, tb_par_q);
      end
      tb_in[1] = 32'h00000003;
      tb_sel = 5'd1;
      @(posedge clk);
      #1;
      total++;
      if (tb_par_q !== 1'b0) begin
         bad++;
         $display("FAIL parity_even sel=%0d got=%b want=0", tb_sel, tb_par_q);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      tb_rst = 1'b1;
      tb_sel = 5'd0;
      for (int i = 0; i < 32; i++) tb_in[i] = 32'h0;
      test_reset();
      tb_rst = 1'b0;
      test_sweep();
      test_unselected();
      test_register();
      test_async_reset();
      test_random();
`ifdef MUX32X32_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
